exe_issue_arbiter: RTL and testbench

EXE_ISSUE_ARBITER -- requirements
Module: exe_issue_arbiter

---
 rtl/exe_issue_arbiter.sv | 147 ++++++++++++++
 tb/tb_exe_issue_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/exe_issue_arbiter.sv
// exe_issue_arbiter: two-source (ALU queue / LS queue) issue arbiter feeding a
// single EXE slot. Round-robin between sources and a multi-cycle occupancy
// window for mult/div ops. It also supports a load-use stall, a global freeze
// and a mispredict flush.
module exe_issue_arbiter #(
  parameter int ROBWIDTH   = 6,
  parameter int MULDIV_LAT = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FREEZE,
  input  logic                Flush_IN,
  input  logic                Hazard_IN,
  input  logic                ALU_req_IN,
  input  logic [ROBWIDTH-1:0] ALU_rob_IN,
  input  logic                ALU_muldiv_IN,
  input  logic                LS_req_IN,
  input  logic [ROBWIDTH-1:0] LS_rob_IN,
  output logic                ALU_grant_OUT,
  output logic                LS_grant_OUT,
  output logic                Issue_Valid_OUT,
  output logic [ROBWIDTH-1:0] Issue_ROB_OUT,
  output logic                Issue_Src_OUT,
  output logic                Busy_OUT
);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  localparam logic [3:0] MD_START = 4'(MULDIV_LAT - 1);

  state_t              r_state, w_state_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic                r_rr_ls, w_rr_next;      // 1: LS wins a tie
  logic                r_valid, w_valid_next;
  logic [ROBWIDTH-1:0] r_rob, w_rob_next;
  logic                r_src, w_src_next;
  logic                r_busy, w_busy_next;
  logic                w_open;
  logic                w_alu_grant, w_ls_grant;

  // State and issue-slot registers; reset dominates everything else.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_ARB;
      r_cnt   <= 4'd0;
      r_rr_ls <= 1'b0;
      r_valid <= 1'b0;
      r_rob   <= '0;
      r_src   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rr_ls <= w_rr_next;
      r_valid <= w_valid_next;
      r_rob   <= w_rob_next;
      r_src   <= w_src_next;
      r_busy  <= w_busy_next;
    end
  end

  // Grant selection and next-state logic; flush beats freeze beats hazard.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rr_next    = r_rr_ls;
    w_valid_next = r_valid;
    w_rob_next   = r_rob;
    w_src_next   = r_src;
    w_busy_next  = r_busy;
    w_alu_grant  = 1'b0;
    w_ls_grant   = 1'b0;

    w_open = (r_state == ST_ARB) && !RESET && !FREEZE && !Flush_IN && !Hazard_IN;
    if (w_open) begin
      if (ALU_req_IN && (!LS_req_IN || !r_rr_ls)) begin
        w_alu_grant = 1'b1;
      end else if (LS_req_IN) begin
        w_ls_grant = 1'b1;
      end
    end

    if (Flush_IN) begin
      w_state_next = ST_ARB;
      w_cnt_next   = 4'd0;
      w_valid_next = 1'b0;
      w_busy_next  = 1'b0;
    end else if (!FREEZE) begin
      case (r_state)
        ST_ARB: begin
          if (Hazard_IN) begin
            // EXE re-evaluates the op already in the slot, so the slot holds.
            w_state_next = ST_STALL;
          end else if (w_alu_grant) begin
            w_valid_next = 1'b1;
            w_rob_next   = ALU_rob_IN;
            w_src_next   = 1'b0;
            w_rr_next    = 1'b1;
            if (ALU_muldiv_IN) begin
              w_state_next = ST_MULDIV;
              w_cnt_next   = MD_START;
              w_busy_next  = 1'b1;
            end
          end else if (w_ls_grant) begin
            w_valid_next = 1'b1;
            w_rob_next   = LS_rob_IN;
            w_src_next   = 1'b1;
            w_rr_next    = 1'b0;
          end else begin
            w_valid_next = 1'b0;
          end
        end
        ST_MULDIV: begin
          // Hazard is irrelevant while the mult/div owns EXE.
          w_valid_next = 1'b0;
          if (r_cnt <= 4'd1) begin
            w_state_next = ST_ARB;
            w_cnt_next   = 4'd0;
            w_busy_next  = 1'b0;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        ST_STALL: begin
          if (!Hazard_IN) begin
            w_state_next = ST_ARB;
          end
        end
        default: begin
          w_state_next = ST_ARB;
        end
      endcase
    end
  end

  assign ALU_grant_OUT   = w_alu_grant;
  assign LS_grant_OUT    = w_ls_grant;
  assign Issue_Valid_OUT = r_valid;
  assign Issue_ROB_OUT   = r_rob;
  assign Issue_Src_OUT   = r_src;
  assign Busy_OUT        = r_busy;

endmodule

// File: tb/tb_exe_issue_arbiter.sv
// tb_exe_issue_arbiter: directed scenarios followed by random traffic. A driver
// computes expected grants and next-cycle outputs from a cycle-level model and
// queues them. A separate monitor pops and compares.
module tb_exe_issue_arbiter;

  localparam int RW  = 6;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          RESET = 1'b1, FREEZE = 1'b0, Flush_IN = 1'b0, Hazard_IN = 1'b0;
  logic          ALU_req_IN = 1'b0, ALU_muldiv_IN = 1'b0, LS_req_IN = 1'b0;
  logic [RW-1:0] ALU_rob_IN = '0, LS_rob_IN = '0;
  logic          ALU_grant_OUT, LS_grant_OUT, Issue_Valid_OUT, Issue_Src_OUT, Busy_OUT;
  logic [RW-1:0] Issue_ROB_OUT;

  always #5 clk = ~clk;

  exe_issue_arbiter #(.ROBWIDTH(RW), .MULDIV_LAT(LAT)) dut (
    .CLK(clk), .RESET(RESET), .FREEZE(FREEZE), .Flush_IN(Flush_IN), .Hazard_IN(Hazard_IN),
    .ALU_req_IN(ALU_req_IN), .ALU_rob_IN(ALU_rob_IN), .ALU_muldiv_IN(ALU_muldiv_IN),
    .LS_req_IN(LS_req_IN), .LS_rob_IN(LS_rob_IN),
    .ALU_grant_OUT(ALU_grant_OUT), .LS_grant_OUT(LS_grant_OUT),
    .Issue_Valid_OUT(Issue_Valid_OUT), .Issue_ROB_OUT(Issue_ROB_OUT),
    .Issue_Src_OUT(Issue_Src_OUT), .Busy_OUT(Busy_OUT)
  );

  typedef struct { bit ag; bit lg; } gexp_t;
  typedef struct { bit valid; logic [RW-1:0] rob; bit src; bit busy; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model: EXE occupancy as a remaining-cycle count, stall as
  // "hazard seen last open cycle", fairness as "who was granted last".
  int            m_busy_left;
  bit            m_stalled;
  bit            m_last_ls;
  bit            m_valid;
  logic [RW-1:0] m_rob;
  bit            m_src;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic frz, input logic fl, input logic hz,
                      input logic areq, input logic [RW-1:0] arob, input logic amd,
                      input logic lreq, input logic [RW-1:0] lrob);
    gexp_t g;
    rexp_t r;
    @(negedge clk);
    RESET = rst; FREEZE = frz; Flush_IN = fl; Hazard_IN = hz;
    ALU_req_IN = areq; ALU_rob_IN = arob; ALU_muldiv_IN = amd;
    LS_req_IN = lreq; LS_rob_IN = lrob;
    #1;
    g.ag = 1'b0;
    g.lg = 1'b0;
    if (!rst && !fl && !frz && !hz && m_busy_left == 0 && !m_stalled) begin
      if (areq && lreq) begin
        if (m_last_ls) g.ag = 1'b1; else g.lg = 1'b1;
      end else if (areq) begin
        g.ag = 1'b1;
      end else if (lreq) begin
        g.lg = 1'b1;
      end
    end
    gq.push_back(g);

    if (rst) begin
      m_busy_left = 0; m_stalled = 0; m_last_ls = 1; m_valid = 0; m_rob = '0; m_src = 0;
    end else if (fl) begin
      m_busy_left = 0; m_stalled = 0; m_valid = 0;
    end else if (frz) begin
      // everything holds
    end else if (m_busy_left > 0) begin
      m_busy_left = m_busy_left - 1;
      m_valid = 0;
    end else if (hz) begin
      m_stalled = 1;
    end else if (m_stalled) begin
      m_stalled = 0;
    end else if (g.ag || g.lg) begin
      m_valid = 1;
      m_src   = g.lg;
      m_rob   = g.lg ? lrob : arob;
      m_last_ls = g.lg;
      if (g.ag && amd) m_busy_left = LAT - 1;
      $display("issue src=%s rob=%0d muldiv=%0d t=%0t", g.lg ? "LS" : "ALU", m_rob, g.ag && amd, $time);
    end else begin
      m_valid = 0;
    end
    r.valid = m_valid;
    r.rob   = m_rob;
    r.src   = m_src;
    r.busy  = (m_busy_left > 0);
    rq.push_back(r);
  endtask

  // Monitor: grants shortly after inputs settle, registers just after the edge.
  initial begin
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (gq.size() > 0) begin
        g = gq.pop_front();
        chk("alu_grant", 32'(ALU_grant_OUT), 32'(g.ag));
        chk("ls_grant",  32'(LS_grant_OUT),  32'(g.lg));
      end
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk("issue_valid", 32'(Issue_Valid_OUT), 32'(r.valid));
        chk("issue_rob",   32'(Issue_ROB_OUT),   32'(r.rob));
        chk("issue_src",   32'(Issue_Src_OUT),   32'(r.src));
        chk("busy",        32'(Busy_OUT),        32'(r.busy));
      end
    end
  end

  initial begin
    // Reset, then ALU/LS alternate on ties.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 5, 0, 1, 9);
    // Mult/div occupies EXE; LS waits LAT cycles.
    step(0, 0, 0, 0, 1, 3, 1, 1, 12);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 12);
    // Hazard holds the issued op.
    step(0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8, 0, 1, 10);
    step(0, 0, 0, 1, 1, 8, 0, 1, 10);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8, 0, 1, 10);
    // Freeze in the middle of a mult/div.
    step(0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 11);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 4, 0, 1, 11);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 4, 0, 1, 11);
    // Flush beats freeze and hazard inside a mult/div.
    step(0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(0, 1, 1, 1, 1, 2, 0, 1, 13);
    step(0, 0, 0, 0, 1, 2, 0, 1, 13);
    step(0, 0, 0, 0, 1, 2, 0, 1, 13);
    // Reset aborts a mult/div; ALU wins first after release.
    step(0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(1, 0, 0, 0, 1, 6, 0, 1, 14);
    step(1, 0, 0, 0, 1, 6, 0, 1, 14);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 6, 0, 1, 14);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 4,   $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 70,  RW'($urandom),
           $urandom_range(0, 99) < 25,  $urandom_range(0, 99) < 60,
           RW'($urandom));
    end
    @(posedge clk);
    #3;
    chk("queues_drained", 32'(gq.size() + rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
